rs_bank: RTL and testbench

Parametrised reservation-station bank for the Tomasulo back end: one instance per functional-unit class (load, store-address, add, mul), replacing the fixed 32/96-entry arrays. It:
- accepts renamed instructions from issue with a valid/ready handshake;
- snoops the common data bus (CDB) to capture pending operands;
- hands fully-ready entries to its functional unit through a registered valid/ready dispatch stage.

Each allocated entry returns its result tag to issue so the register-result-status table can be updated.

---
 rtl/rs_pkg.sv | 36 +++
 rtl/rs_bank_if.sv | 43 ++++
 rtl/rs_pick.sv | 20 ++
 rtl/rs_bank.sv | 168 ++++++++++++++++
 tb/tb_rs_bank.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared types for the reservation-station banks: operand and entry records,
// tag composition and functional-unit IDs.
package rs_pkg;

   localparam int unsigned RS_WORD_W = 32;
   localparam int unsigned RS_TAG_W  = 8;
   localparam int unsigned RS_OP_W   = 4;

   typedef enum logic [2:0] {
      UNIT_SW  = 3'd0,
      UNIT_ADD = 3'd1,
      UNIT_MUL = 3'd2,
      UNIT_LW  = 3'd4
   } rs_unit_e;

   typedef struct packed {
      logic                 rdy;
      logic [RS_WORD_W-1:0] val;
      logic [RS_TAG_W-1:0]  tag;
   } rs_operand_t;

   typedef struct packed {
      logic               valid;
      logic [RS_OP_W-1:0] op;
      rs_operand_t        s1;
      rs_operand_t        s2;
   } rs_entry_t;

   // tag = {unit_id, entry index}
   function automatic logic [RS_TAG_W-1:0] rs_make_tag(input int unsigned unit_id,
                                                       input int unsigned idx,
                                                       input int unsigned idx_w);
      return RS_TAG_W'((unit_id << idx_w) | idx);
   endfunction

endpackage

// File: rtl/rs_bank_if.sv
// Issue, CDB and dispatch signal bundle of a reservation-station bank.
// master = surrounding pipeline, slave = rs_bank.
interface rs_bank_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned OP_W   = 4
);
   logic              issue_valid;
   logic              issue_ready;
   logic [OP_W-1:0]   issue_op;
   logic              issue_s1_rdy;
   logic              issue_s2_rdy;
   logic [WORD_W-1:0] issue_s1_val;
   logic [WORD_W-1:0] issue_s2_val;
   logic [TAG_W-1:0]  issue_s1_tag;
   logic [TAG_W-1:0]  issue_s2_tag;
   logic [TAG_W-1:0]  issue_tag;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [WORD_W-1:0] cdb_data;

   logic              disp_valid;
   logic              disp_ready;
   logic [OP_W-1:0]   disp_op;
   logic [WORD_W-1:0] disp_a;
   logic [WORD_W-1:0] disp_b;
   logic [TAG_W-1:0]  disp_tag;

   modport master (
      output issue_valid, issue_op, issue_s1_rdy, issue_s2_rdy, issue_s1_val,
             issue_s2_val, issue_s1_tag, issue_s2_tag, cdb_valid, cdb_tag,
             cdb_data, disp_ready,
      input  issue_ready, issue_tag, disp_valid, disp_op, disp_a, disp_b, disp_tag
   );

   modport slave (
      input  issue_valid, issue_op, issue_s1_rdy, issue_s2_rdy, issue_s1_val,
             issue_s2_val, issue_s1_tag, issue_s2_tag, cdb_valid, cdb_tag,
             cdb_data, disp_ready,
      output issue_ready, issue_tag, disp_valid, disp_op, disp_a, disp_b, disp_tag
   );
endinterface

// File: rtl/rs_pick.sv
// Find-first-set: index of the lowest set bit of vec, plus a found flag.
module rs_pick #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          found
);
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec[i] && !found) begin
            idx   = i[IW-1:0];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: issue allocation, CDB operand capture and a
// registered dispatch stage. Define RS_AGE_ORDER_EN for oldest-first dispatch.
module rs_bank
   import rs_pkg::*;
#(
   parameter int unsigned WORD_W  = RS_WORD_W,
   parameter int unsigned TAG_W   = RS_TAG_W,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned UNIT_ID = 0,
   parameter int unsigned OP_W    = RS_OP_W,
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   rs_bank_if.slave     bus,
   output logic [IDX_W:0] occupancy
);
   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

   rs_entry_t         ent [DEPTH];
   rs_entry_t         new_ent;
   logic [DEPTH-1:0]  free_vec;
   logic [DEPTH-1:0]  rdy_vec;
   logic [IDX_W-1:0]  alloc_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic              alloc_found;
   logic              sel_found;
   logic              issue_fire;
   logic              load_fire;
   logic              stage_open;

   logic              disp_valid_q;
   logic [OP_W-1:0]   disp_op_q;
   logic [WORD_W-1:0] disp_a_q;
   logic [WORD_W-1:0] disp_b_q;
   logic [TAG_W-1:0]  disp_tag_q;

   always_comb begin
      free_vec = '0;
      rdy_vec  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         free_vec[i] = !ent[i].valid;
         rdy_vec[i]  = ent[i].valid && ent[i].s1.rdy && ent[i].s2.rdy;
      end
   end

   rs_pick #(.N(DEPTH), .IW(IDX_W)) u_alloc (
      .vec(free_vec), .idx(alloc_idx), .found(alloc_found)
   );

`ifdef RS_AGE_ORDER_EN
   logic [IDX_W-1:0] age [DEPTH];
   logic [IDX_W-1:0] best_age;

   // Ages of valid entries are unique, so the strict compare picks one winner.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      best_age  = '1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (rdy_vec[i] && (!sel_found || age[i] < best_age)) begin
            sel_idx   = i[IDX_W-1:0];
            sel_found = 1'b1;
            best_age  = age[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (load_fire && ent[i].valid && age[i] > age[sel_idx])
               age[i] <= age[i] - 1'b1;
         end
         if (issue_fire)
            age[alloc_idx] <= occupancy[IDX_W-1:0] - IDX_W'(load_fire);
      end
   end
`else
   rs_pick #(.N(DEPTH), .IW(IDX_W)) u_sel (
      .vec(rdy_vec), .idx(sel_idx), .found(sel_found)
   );
`endif

   assign bus.issue_ready = (occupancy < FULL_CNT) && alloc_found && !flush;
   assign bus.issue_tag   = rs_make_tag(UNIT_ID, 32'(alloc_idx), IDX_W);
   assign issue_fire      = bus.issue_valid && bus.issue_ready;
   assign stage_open      = !disp_valid_q || bus.disp_ready;
   assign load_fire       = sel_found && stage_open;

   // Issuing operands can be woken by a broadcast in the same cycle.
   always_comb begin
      new_ent.valid  = 1'b1;
      new_ent.op     = bus.issue_op;
      new_ent.s1.tag = bus.issue_s1_tag;
      new_ent.s2.tag = bus.issue_s2_tag;
      new_ent.s1.rdy = bus.issue_s1_rdy;
      new_ent.s1.val = bus.issue_s1_val;
      new_ent.s2.rdy = bus.issue_s2_rdy;
      new_ent.s2.val = bus.issue_s2_val;
      if (!bus.issue_s1_rdy && bus.cdb_valid && bus.issue_s1_tag == bus.cdb_tag) begin
         new_ent.s1.rdy = 1'b1;
         new_ent.s1.val = bus.cdb_data;
      end
      if (!bus.issue_s2_rdy && bus.cdb_valid && bus.issue_s2_tag == bus.cdb_tag) begin
         new_ent.s2.rdy = 1'b1;
         new_ent.s2.val = bus.cdb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent[i].valid && bus.cdb_valid) begin
               if (!ent[i].s1.rdy && ent[i].s1.tag == bus.cdb_tag) begin
                  ent[i].s1.rdy <= 1'b1;
                  ent[i].s1.val <= bus.cdb_data;
               end
               if (!ent[i].s2.rdy && ent[i].s2.tag == bus.cdb_tag) begin
                  ent[i].s2.rdy <= 1'b1;
                  ent[i].s2.val <= bus.cdb_data;
               end
            end
         end
         if (load_fire)  ent[sel_idx].valid <= 1'b0;
         if (issue_fire) ent[alloc_idx]     <= new_ent;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush)
         occupancy <= '0;
      else
         occupancy <= occupancy + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(load_fire);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp_valid_q <= 1'b0;
         disp_op_q    <= '0;
         disp_a_q     <= '0;
         disp_b_q     <= '0;
         disp_tag_q   <= '0;
      end else if (flush) begin
         disp_valid_q <= 1'b0;
      end else if (stage_open) begin
         disp_valid_q <= sel_found;
         if (sel_found) begin
            disp_op_q  <= ent[sel_idx].op;
            disp_a_q   <= ent[sel_idx].s1.val;
            disp_b_q   <= ent[sel_idx].s2.val;
            disp_tag_q <= rs_make_tag(UNIT_ID, 32'(sel_idx), IDX_W);
         end
      end
   end

   assign bus.disp_valid = disp_valid_q;
   assign bus.disp_op    = disp_op_q;
   assign bus.disp_a     = disp_a_q;
   assign bus.disp_b     = disp_b_q;
   assign bus.disp_tag   = disp_tag_q;

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank: DEPTH=4, UNIT_ID=1, so tags are 0x04 + index.
module tb_rs_bank;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [2:0] occupancy;
   int         n_checks = 0;
   int         n_fail   = 0;

   rs_bank_if #(.WORD_W(32), .TAG_W(8), .OP_W(4)) bus ();

   rs_bank #(.WORD_W(32), .TAG_W(8), .DEPTH(4), .UNIT_ID(1), .OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.issue_valid  = 1'b0;
      bus.issue_op     = '0;
      bus.issue_s1_rdy = 1'b0;
      bus.issue_s2_rdy = 1'b0;
      bus.issue_s1_val = '0;
      bus.issue_s2_val = '0;
      bus.issue_s1_tag = '0;
      bus.issue_s2_tag = '0;
      bus.cdb_valid    = 1'b0;
      bus.cdb_tag      = '0;
      bus.cdb_data     = '0;
   endtask

   task automatic set_cdb(input logic v, input logic [7:0] t, input logic [31:0] d);
      bus.cdb_valid = v;
      bus.cdb_tag   = t;
      bus.cdb_data  = d;
   endtask

   // Drives one issue for one cycle; returns tag/ready seen before the edge.
   task automatic do_issue(input logic [3:0] op,
                           input logic r1, input logic [31:0] v1, input logic [7:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [7:0] t2,
                           output logic [7:0] tag_seen, output logic rdy_seen);
      bus.issue_valid  = 1'b1;
      bus.issue_op     = op;
      bus.issue_s1_rdy = r1;
      bus.issue_s1_val = v1;
      bus.issue_s1_tag = t1;
      bus.issue_s2_rdy = r2;
      bus.issue_s2_val = v2;
      bus.issue_s2_tag = t2;
      #1;
      tag_seen = bus.issue_tag;
      rdy_seen = bus.issue_ready;
      step();
      bus.issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      bus.disp_ready = 1'b0;
      idle_inputs();
      step();
      step();
      #1;
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %0b want 1", bus.issue_ready); end
      n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid: got %0b want 0", bus.disp_valid); end
      n_checks++; if (bus.disp_op !== 4'h0 || bus.disp_tag !== 8'h00) begin n_fail++; $display("FAIL reset_disp_op_tag: got %h/%h want 0/00", bus.disp_op, bus.disp_tag); end
      n_checks++; if (bus.disp_a !== 32'h0 || bus.disp_b !== 32'h0) begin n_fail++; $display("FAIL reset_disp_ab: got %h/%h want 0/0", bus.disp_a, bus.disp_b); end
      n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      n_checks++; if (bus.issue_tag !== 8'h04) begin n_fail++; $display("FAIL reset_issue_tag: got %h want 04", bus.issue_tag); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [7:0] tg;
      logic       rd;
      bus.disp_ready = 1'b1;
      do_issue(4'h3, 1'b1, 32'd5, 8'h00, 1'b1, 32'd7, 8'h00, tg, rd);
      n_checks++; if (tg !== 8'h04 || rd !== 1'b1) begin n_fail++; $display("FAIL basic_issue_tag: got %h/%0b want 04/1", tg, rd); end
      n_checks++; if (bus.disp_valid !== 1'b0 || occupancy !== 3'd1) begin n_fail++; $display("FAIL basic_t1: got valid %0b occ %0d want 0/1", bus.disp_valid, occupancy); end
      step();
      n_checks++; if (bus.disp_valid !== 1'b1 || occupancy !== 3'd0) begin n_fail++; $display("FAIL basic_t2_valid: got valid %0b occ %0d want 1/0", bus.disp_valid, occupancy); end
      n_checks++; if (bus.disp_a !== 32'd5 || bus.disp_b !== 32'd7) begin n_fail++; $display("FAIL basic_t2_ab: got %h/%h want 5/7", bus.disp_a, bus.disp_b); end
      n_checks++; if (bus.disp_tag !== 8'h04 || bus.disp_op !== 4'h3) begin n_fail++; $display("FAIL basic_t2_tag_op: got %h/%h want 04/3", bus.disp_tag, bus.disp_op); end
      step();
      n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", bus.disp_valid); end
   endtask

   task automatic test_cdb_wakeup();
      logic [7:0] tg;
      logic       rd;
      bus.disp_ready = 1'b1;
      do_issue(4'h5, 1'b0, 32'h0, 8'h21, 1'b1, 32'h1, 8'h00, tg, rd);
      set_cdb(1'b1, 8'h22, 32'h0BAD);
      step();
      set_cdb(1'b0, 8'h00, 32'h0);
      n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wrongtag_t1: got %0b want 0", bus.disp_valid); end
      step();
      n_checks++; if (bus.disp_valid !== 1'b0 || occupancy !== 3'd1) begin n_fail++; $display("FAIL wake_wrongtag_t2: got valid %0b occ %0d want 0/1", bus.disp_valid, occupancy); end
      set_cdb(1'b1, 8'h21, 32'hDEAD);
      step();
      set_cdb(1'b0, 8'h00, 32'h0);
      n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_t1: got %0b want 0", bus.disp_valid); end
      step();
      n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_a !== 32'hDEAD) begin n_fail++; $display("FAIL wake_t2: got valid %0b a %h want 1/0000dead", bus.disp_valid, bus.disp_a); end
      n_checks++; if (bus.disp_b !== 32'h1 || bus.disp_op !== 4'h5 || bus.disp_tag !== 8'h04) begin n_fail++; $display("FAIL wake_t2_fields: got b %h op %h tag %h want 1/5/04", bus.disp_b, bus.disp_op, bus.disp_tag); end
      step();
   endtask

   task automatic test_bypass();
      logic [7:0] tg;
      logic       rd;
      bus.disp_ready = 1'b1;
      set_cdb(1'b1, 8'h30, 32'd9);
      do_issue(4'h2, 1'b1, 32'd2, 8'h00, 1'b0, 32'h0, 8'h30, tg, rd);
      set_cdb(1'b0, 8'h00, 32'h0);
      n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_t1: got %0b want 0", bus.disp_valid); end
      step();
      n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_a !== 32'd2 || bus.disp_b !== 32'd9) begin n_fail++; $display("FAIL bypass_t2: got valid %0b a %h b %h want 1/2/9", bus.disp_valid, bus.disp_a, bus.disp_b); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  tg;
      logic        rd;
      logic [31:0] exp_a [4];
`ifdef RS_AGE_ORDER_EN
      exp_a[0] = 32'h11; exp_a[1] = 32'h12; exp_a[2] = 32'h13; exp_a[3] = 32'h14;
`else
      exp_a[0] = 32'h12; exp_a[1] = 32'h11; exp_a[2] = 32'h13; exp_a[3] = 32'h14;
`endif
      bus.disp_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         do_issue(4'(i), 1'b1, 32'h10 + 32'(i), 8'h00, 1'b1, 32'h20 + 32'(i), 8'h00, tg, rd);
      #1;
      n_checks++; if (bus.issue_ready !== 1'b0 || occupancy !== 3'd4) begin n_fail++; $display("FAIL full_state: got ready %0b occ %0d want 0/4", bus.issue_ready, occupancy); end
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_a !== 32'h10) begin n_fail++; $display("FAIL full_hold[%0d]: got valid %0b a %h want 1/10", i, bus.disp_valid, bus.disp_a); end
         step();
      end
      bus.disp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_a !== exp_a[k]) begin n_fail++; $display("FAIL drain[%0d]: got valid %0b a %h want 1/%h", k, bus.disp_valid, bus.disp_a, exp_a[k]); end
         if (k == 0) begin
            n_checks++; if (bus.issue_ready !== 1'b1 || occupancy !== 3'd3) begin n_fail++; $display("FAIL drain_ready_rise: got ready %0b occ %0d want 1/3", bus.issue_ready, occupancy); end
         end
      end
      step();
      n_checks++; if (bus.disp_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got valid %0b occ %0d want 0/0", bus.disp_valid, occupancy); end
   endtask

   task automatic test_order();
      logic [7:0]  tg;
      logic        rd;
      logic [7:0]  exp_tag [3];
      logic [31:0] exp_b [3];
`ifdef RS_AGE_ORDER_EN
      exp_tag[0] = 8'h05; exp_tag[1] = 8'h06; exp_tag[2] = 8'h04;
      exp_b[0] = 32'hB; exp_b[1] = 32'hC; exp_b[2] = 32'hD;
`else
      exp_tag[0] = 8'h04; exp_tag[1] = 8'h05; exp_tag[2] = 8'h06;
      exp_b[0] = 32'hD; exp_b[1] = 32'hB; exp_b[2] = 32'hC;
`endif
      bus.disp_ready = 1'b1;
      do_issue(4'h1, 1'b0, 32'h0, 8'h40, 1'b1, 32'hA, 8'h00, tg, rd);
      do_issue(4'h1, 1'b0, 32'h0, 8'h50, 1'b1, 32'hB, 8'h00, tg, rd);
      do_issue(4'h1, 1'b0, 32'h0, 8'h50, 1'b1, 32'hC, 8'h00, tg, rd);
      n_checks++; if (tg !== 8'h06 || occupancy !== 3'd3) begin n_fail++; $display("FAIL order_alloc: got tag %h occ %0d want 06/3", tg, occupancy); end
      set_cdb(1'b1, 8'h40, 32'h1);
      step();
      set_cdb(1'b0, 8'h00, 32'h0);
      step();
      n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_tag !== 8'h04 || bus.disp_b !== 32'hA) begin n_fail++; $display("FAIL order_first: got valid %0b tag %h b %h want 1/04/a", bus.disp_valid, bus.disp_tag, bus.disp_b); end
      do_issue(4'h1, 1'b0, 32'h0, 8'h50, 1'b1, 32'hD, 8'h00, tg, rd);
      n_checks++; if (tg !== 8'h04 || bus.disp_valid !== 1'b0 || occupancy !== 3'd3) begin n_fail++; $display("FAIL order_reuse: got tag %h valid %0b occ %0d want 04/0/3", tg, bus.disp_valid, occupancy); end
      set_cdb(1'b1, 8'h50, 32'h77);
      step();
      set_cdb(1'b0, 8'h00, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_tag !== exp_tag[k] || bus.disp_b !== exp_b[k]) begin n_fail++; $display("FAIL order[%0d]: got valid %0b tag %h b %h want 1/%h/%h", k, bus.disp_valid, bus.disp_tag, bus.disp_b, exp_tag[k], exp_b[k]); end
         n_checks++; if (bus.disp_a !== 32'h77) begin n_fail++; $display("FAIL order_a[%0d]: got %h want 77", k, bus.disp_a); end
      end
      step();
      n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %0b want 0", bus.disp_valid); end
   endtask

   task automatic fill_three(output logic ok);
      logic [7:0] tg;
      logic       rd;
      bus.disp_ready = 1'b0;
      do_issue(4'h7, 1'b1, 32'h77, 8'h00, 1'b1, 32'h1, 8'h00, tg, rd);
      for (int i = 0; i < 3; i++)
         do_issue(4'h6, 1'b0, 32'h0, 8'h60, 1'b1, 32'h2, 8'h00, tg, rd);
      ok = (occupancy == 3'd3) && (bus.disp_valid == 1'b1);
   endtask

   task automatic test_flush();
      logic       ok;
      logic [7:0] tg;
      logic       rd;
      fill_three(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got occ %0d valid %0b want 3/1", occupancy, bus.disp_valid); end
      flush = 1'b1;
      bus.issue_valid = 1'b1; bus.issue_s1_rdy = 1'b1; bus.issue_s2_rdy = 1'b1;
      set_cdb(1'b1, 8'h60, 32'h5);
      #1;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_issue_ready: got %0b want 0", bus.issue_ready); end
      step();
      flush = 1'b0;
      idle_inputs();
      n_checks++; if (occupancy !== 3'd0 || bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got occ %0d valid %0b want 0/0", occupancy, bus.disp_valid); end
      step();
      n_checks++; if (occupancy !== 3'd0 || bus.disp_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got occ %0d valid %0b ready %0b want 0/0/1", occupancy, bus.disp_valid, bus.issue_ready); end

      fill_three(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got occ %0d valid %0b want 3/1", occupancy, bus.disp_valid); end
      rst_n = 1'b0;
      bus.issue_valid = 1'b1; bus.issue_s1_rdy = 1'b1; bus.issue_s2_rdy = 1'b1;
      set_cdb(1'b1, 8'h60, 32'h5);
      step();
      rst_n = 1'b1;
      idle_inputs();
      n_checks++; if (occupancy !== 3'd0 || bus.disp_valid !== 1'b0 || bus.disp_a !== 32'h0) begin n_fail++; $display("FAIL rst_clear: got occ %0d valid %0b a %h want 0/0/0", occupancy, bus.disp_valid, bus.disp_a); end
      bus.disp_ready = 1'b1;
      do_issue(4'h1, 1'b1, 32'h3, 8'h00, 1'b1, 32'h4, 8'h00, tg, rd);
      n_checks++; if (tg !== 8'h04 || rd !== 1'b1) begin n_fail++; $display("FAIL rst_realloc: got tag %h ready %0b want 04/1", tg, rd); end
      step();
      n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_a !== 32'h3) begin n_fail++; $display("FAIL rst_redisp: got valid %0b a %h want 1/3", bus.disp_valid, bus.disp_a); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cdb_wakeup();
      test_bypass();
      test_back_to_back();
      test_order();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
